// File: rtl/smr_mem_pkg.sv
// rtl/smr_mem_pkg.sv - memory command encodings and access FSM state type
package smr_mem_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_STORE = 2'd3
  } mau_state_t;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with reset vector, increment and branch load
module pc_unit #(
  parameter int unsigned       ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // branch load has priority; the increment wraps modulo 2^ADDR_W
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // PC register, returns to the reset vector on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - fetch/load/store engine with wait states (optional MEM_TIMEOUT_EN)
module mem_access_unit
  import smr_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned     TIMEOUT_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_fetch,
  input  logic              req_load,
  input  logic              req_store,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_ready,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mau_state_t        state_q, state_d;
  logic [ADDR_W-1:0] da_q;
  logic [ADDR_W-1:0] acc_addr_q;
  logic [DATA_W-1:0] instr_q, rdata_q, wdata_q;
  logic              done_q;
  logic              idle, complete, abort;
  logic              accept_fetch, accept_load, accept_store;

  assign idle         = (state_q == S_IDLE);
  assign accept_fetch = idle & req_fetch;
  assign accept_load  = idle & ~req_fetch & req_load;
  assign accept_store = idle & ~req_fetch & ~req_load & req_store;
  assign complete     = ~idle & mem_ready;

  pc_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load_i  (idle & pc_load),
    .target_i(pc_target),
    .inc_i   (complete & (state_q == S_FETCH)),
    .pc_o    (pc)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q;

  // the TIMEOUT_CYC-th consecutive wait cycle gives up on the access
  assign abort = ~idle & ~mem_ready & (wait_q == WAIT_LAST);

  // count wait states of the current access; cleared when idle, on completion and on abort
  always_comb begin
    wait_d = wait_q + 1'b1;
    if (idle || mem_ready || abort) begin
      wait_d = '0;
    end
  end

  // wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  // access sequencing: highest-priority request in IDLE, back to IDLE on ready or abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_fetch) begin
          state_d = S_FETCH;
        end else if (accept_load) begin
          state_d = S_LOAD;
        end else if (accept_store) begin
          state_d = S_STORE;
        end
      end
      default: begin
        if (complete || abort) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // state, address/data capture and completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      da_q       <= '0;
      acc_addr_q <= '0;
      instr_q    <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= complete | abort;
      if (load_addr) begin
        da_q <= addr_in;
      end
      // the access keeps the DA value seen at accept, later load_addr only affects the next one
      if (accept_load || accept_store) begin
        acc_addr_q <= da_q;
      end
      if (accept_store) begin
        wdata_q <= wdata_in;
      end
      if (complete && state_q == S_FETCH) begin
        instr_q <= read_data;
      end
      if (complete && state_q == S_LOAD) begin
        rdata_q <= read_data;
      end
    end
  end

  // bus command and address mux
  always_comb begin
    mem_cmd  = MNONE;
    mem_addr = da_q;
    case (state_q)
      S_FETCH: begin
        mem_cmd  = MREAD;
        mem_addr = pc;
      end
      S_LOAD: begin
        mem_cmd  = MREAD;
        mem_addr = acc_addr_q;
      end
      S_STORE: begin
        mem_cmd  = MWRITE;
        mem_addr = acc_addr_q;
      end
      default: ;
    endcase
  end

  assign write_data  = wdata_q;
  assign instruction = instr_q;
  assign rdata       = rdata_q;
  assign busy        = ~idle;
  assign done        = done_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized bench with transaction-level model for mem_access_unit
module tb_mem_access_unit;

  localparam int TIMEOUT_CYC = 15;
  localparam int K_FETCH = 0, K_LOAD = 1, K_STORE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_fetch = 1'b0, req_load = 1'b0, req_store = 1'b0;
  logic        load_addr = 1'b0, pc_load = 1'b0, mem_ready = 1'b0;
  logic [8:0]  addr_in = '0, pc_target = '0;
  logic [15:0] wdata_in = '0, read_data = '0;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr, pc;
  logic [15:0] write_data, instruction, rdata;
  logic        busy, done, err;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(9), .DATA_W(16), .RESET_PC(9'h000)) dut (
    .clk(clk), .reset(reset), .req_fetch(req_fetch), .req_load(req_load),
    .req_store(req_store), .load_addr(load_addr), .addr_in(addr_in),
    .pc_load(pc_load), .pc_target(pc_target), .wdata_in(wdata_in),
    .read_data(read_data), .mem_ready(mem_ready), .mem_cmd(mem_cmd),
    .mem_addr(mem_addr), .write_data(write_data), .instruction(instruction),
    .rdata(rdata), .pc(pc), .busy(busy), .done(done), .err(err)
  );

  // memory image and transaction-level model of the engine
  logic [15:0] mem [512];
  bit          m_busy, m_done, m_err;
  int          m_kind, m_wait;
  logic [8:0]  m_pc, m_da, m_acc;
  logic [15:0] m_ir, m_rd, m_wd;

  // stimulus for the next cycle
  logic        s_fetch, s_load, s_store, s_laddr, s_pcl, s_ready, s_reset;
  logic [8:0]  s_addr, s_pct;
  logic [15:0] s_wdata;

  int n_total = 0, n_pass = 0, done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [8:0] exp_addr();
    if (!m_busy) return m_da;
    return (m_kind == K_FETCH) ? m_pc : m_acc;
  endfunction

  function automatic logic [1:0] exp_cmd();
    if (!m_busy) return 2'b00;
    return (m_kind == K_STORE) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_kind = K_FETCH; m_wait = 0;
    m_pc = 9'h000; m_da = '0; m_acc = '0; m_ir = '0; m_rd = '0; m_wd = '0;
  endtask

  // one clock of the engine, described as: start, finish or keep waiting on an access
  task automatic model_advance();
    m_done = 0;
    if (!m_busy) begin
      if (s_pcl) m_pc = s_pct;
      m_wait = 0;
      if (s_fetch) begin
        m_busy = 1; m_kind = K_FETCH;
      end else if (s_load) begin
        m_busy = 1; m_kind = K_LOAD; m_acc = m_da;
      end else if (s_store) begin
        m_busy = 1; m_kind = K_STORE; m_acc = m_da; m_wd = s_wdata;
      end
    end else if (s_ready) begin
      if (m_kind == K_FETCH) begin
        m_ir = mem[m_pc]; m_pc = m_pc + 9'd1;
      end else if (m_kind == K_LOAD) begin
        m_rd = mem[m_acc];
      end else begin
        mem[m_acc] = m_wd;
      end
      m_busy = 0; m_done = 1;
    end else begin
      m_wait++;
`ifdef MEM_TIMEOUT_EN
      if (m_wait == TIMEOUT_CYC) begin
        m_busy = 0; m_done = 1; m_err = 1;
      end
`endif
    end
    if (s_laddr) m_da = s_addr;
  endtask

  task automatic compare_all();
    chk("mem_cmd", 32'(mem_cmd), 32'(exp_cmd()));
    chk("mem_addr", 32'(mem_addr), 32'(exp_addr()));
    chk("write_data", 32'(write_data), 32'(m_wd));
    chk("instruction", 32'(instruction), 32'(m_ir));
    chk("rdata", 32'(rdata), 32'(m_rd));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    if (done === 1'b1) done_seen++;
  endtask

  // compare on the falling edge, then drive the inputs for the next rising edge
  task automatic cycle();
    @(negedge clk);
    compare_all();
    req_fetch = s_fetch; req_load = s_load; req_store = s_store;
    load_addr = s_laddr; addr_in = s_addr; pc_load = s_pcl; pc_target = s_pct;
    wdata_in = s_wdata; mem_ready = s_ready; reset = s_reset;
    read_data = mem[exp_addr()];
    if (!s_reset) model_reset();
    else model_advance();
  endtask

  task automatic idle_stim();
    s_fetch = 0; s_load = 0; s_store = 0; s_laddr = 0; s_pcl = 0;
    s_ready = 0; s_reset = 1; s_addr = '0; s_pct = '0; s_wdata = 16'h5555;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    mem[9'h000] = 16'hD105;
    mem[9'h0A3] = 16'h1234;
    model_reset();
    idle_stim();
    s_reset = 0;
    repeat (2) cycle();
    chk("reset_cmd", 32'(mem_cmd), 32'h0);
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    s_reset = 1;
    cycle();

    // fetch with zero-wait memory
    s_fetch = 1; s_ready = 1; cycle();
    s_fetch = 0; cycle();
    chk("f_cmd_c1", 32'(mem_cmd), 32'h1);
    chk("f_addr_c1", 32'(mem_addr), 32'h000);
    cycle();
    chk("f_done_c2", 32'(done), 32'h1);
    chk("f_instr", 32'(instruction), 32'hD105);
    chk("f_pc", 32'(pc), 32'h001);
    s_ready = 0; cycle();
    chk("f_done_off", 32'(done), 32'h0);

    // load with three wait states
    s_laddr = 1; s_addr = 9'h0A3; cycle();
    s_laddr = 0; s_load = 1; cycle();
    s_load = 0;
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      s_ready = (k == 3);
      cycle();
      chk("l_cmd", 32'(mem_cmd), 32'h1);
      chk("l_addr", 32'(mem_addr), 32'h0A3);
    end
    s_ready = 0; cycle();
    chk("l_rdata", 32'(rdata), 32'h1234);
    cycle();
    chk("l_one_done", 32'(done_seen), 32'd1);

    // store, DA updated mid-access must not move the bus address
    s_laddr = 1; s_addr = 9'h010; cycle();
    s_laddr = 0; s_store = 1; s_wdata = 16'hBEEF; cycle();
    s_store = 0; s_wdata = 16'h5555; s_laddr = 1; s_addr = 9'h020; cycle();
    chk("s_cmd", 32'(mem_cmd), 32'h2);
    s_laddr = 0;
    for (int k = 0; k < 2; k++) begin
      s_ready = (k == 1);
      cycle();
      chk("s_addr", 32'(mem_addr), 32'h010);
      chk("s_wdata", 32'(write_data), 32'hBEEF);
    end
    s_ready = 0; cycle();
    chk("s_done", 32'(done), 32'h1);
    chk("s_idle_da", 32'(mem_addr), 32'h020);
    chk("s_mem", 32'(mem[9'h010]), 32'hBEEF);

    // branch coinciding with fetch, PC wraps afterwards
    s_pcl = 1; s_pct = 9'h1FF; s_fetch = 1; s_ready = 1; cycle();
    s_pcl = 0; s_fetch = 0; cycle();
    chk("b_addr", 32'(mem_addr), 32'h1FF);
    cycle();
    chk("b_pc_wrap", 32'(pc), 32'h000);

    // fetch+store together, then load while busy: only the fetch runs
    s_ready = 0; s_fetch = 1; s_store = 1; cycle();
    s_fetch = 0; s_store = 0; s_load = 1; done_seen = 0; cycle();
    chk("p_cmd", 32'(mem_cmd), 32'h1);
    s_load = 0; s_ready = 1; cycle();
    s_ready = 0; cycle(); cycle(); cycle();
    chk("p_one_done", 32'(done_seen), 32'd1);
    chk("p_pc", 32'(pc), 32'h001);
    chk("p_idle", 32'(busy), 32'h0);

`ifdef MEM_TIMEOUT_EN
    // memory never answers: abort after the timeout, PC untouched
    s_load = 1; cycle();
    s_load = 0;
    repeat (TIMEOUT_CYC) cycle();
    cycle();
    chk("t_done", 32'(done), 32'h1);
    chk("t_err", 32'(err), 32'h1);
    chk("t_pc", 32'(pc), 32'h001);
`endif

    // asynchronous reset in the middle of a fetch
    s_fetch = 1; cycle();
    s_fetch = 0; cycle();
    chk("r_cmd_before", 32'(mem_cmd), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("r_cmd", 32'(mem_cmd), 32'h0);
    chk("r_pc", 32'(pc), 32'h000);
    chk("r_err", 32'(err), 32'h0);
    chk("r_done", 32'(done), 32'h0);
    model_reset();
    s_reset = 0; cycle();
    s_reset = 1; cycle();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s_fetch = ($urandom_range(0, 3) == 0);
      s_load  = ($urandom_range(0, 3) == 0);
      s_store = ($urandom_range(0, 3) == 0);
      s_laddr = ($urandom_range(0, 4) == 0);
      s_addr  = 9'($urandom);
      s_pcl   = ($urandom_range(0, 7) == 0);
      s_pct   = 9'($urandom);
      s_wdata = 16'($urandom);
      s_ready = (i % 300 > 270) ? 1'b0 : ($urandom_range(0, 2) != 0);
      s_reset = ($urandom_range(0, 199) != 0);
      cycle();
    end
    idle_stim();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised fetch/load/store engine for the simple RISC machine core; replaces the fixed 9-bit PC, instruction register, data-address register and address mux.
- Adds a memory-ready handshake with wait states.
- Adds PC branch load and a configurable reset vector.
- Sits between the controller FSM (request/done handshake) and the memory bus (mem_cmd/mem_addr/read_data/write_data).

Parameters:
- ADDR_W, 9, width of PC, data-address register and mem_addr.
- DATA_W, 16, width of instruction, read and write data.
- RESET_PC, 0, PC value after reset (ADDR_W bits).
- TIMEOUT_CYC, 15, maximum wait cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_fetch  in  1  single-cycle request: read mem[PC] into IR
- req_load  in  1  single-cycle request: read mem[DA] into rdata
- req_store  in  1  single-cycle request: write wdata_in to mem[DA]
- load_addr  in  1  capture addr_in into DA (any state)
- addr_in  in  ADDR_W  data address source (datapath output)
- pc_load  in  1  replace PC with pc_target (branch)
- pc_target  in  ADDR_W  branch target
- wdata_in  in  DATA_W  store data
- read_data  in  DATA_W  memory read data
- mem_ready  in  1  memory completes the current access this cycle
- mem_cmd  out  2  MNONE/MREAD/MWRITE
- mem_addr  out  ADDR_W  PC during fetch, DA otherwise
- write_data  out  DATA_W  wdata_in registered at store accept
- instruction  out  DATA_W  instruction register
- rdata  out  DATA_W  last loaded data word
- pc  out  ADDR_W  current PC
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse when an access completes
- err  out  1  sticky timeout flag (0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, pc=RESET_PC, DA=0.
  - instruction=0, rdata=0, write_data=0.
  - mem_cmd=MNONE, busy=0, done=0, err=0, wait counter=0.
- States: IDLE, FETCH, LOAD, STORE.
- IDLE:
  - mem_cmd=MNONE, mem_addr=DA.
  - Request priority: fetch > load > store. Lower-priority requests in the same cycle are dropped.
  - Requests arriving while busy=1 are ignored; the controller must wait for done.
- FETCH:
  - mem_cmd=MREAD, mem_addr=pc.
  - On the cycle mem_ready=1: instruction<=read_data, pc<=pc+1 (wraps modulo 2^ADDR_W), done pulse next cycle, return to IDLE.
- LOAD:
  - mem_cmd=MREAD, mem_addr=DA.
  - On mem_ready: rdata<=read_data, done, return to IDLE.
- STORE:
  - mem_cmd=MWRITE, mem_addr=DA, write_data stable for the whole access.
  - On mem_ready: done, return to IDLE.
- Latency: accept at cycle 0; command on the bus from cycle 1; done is asserted in the cycle after mem_ready is sampled high. Zero-wait memory gives done at cycle 2.
- mem_ready is ignored in IDLE.
- pc_load:
  - Honoured only in IDLE.
  - If it coincides with req_fetch, the fetch uses pc_target and pc ends at pc_target+1.
  - pc_load while busy is ignored.
- load_addr:
  - Updates DA in any state.
  - The in-flight LOAD/STORE keeps its address latched at accept; DA change applies to the next access.
- Reset mid-access: immediate abort; no done pulse; pc returns to RESET_PC.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Wait counter (width clog2(TIMEOUT_CYC+1)) increments each busy cycle without mem_ready.
  - When the count reaches TIMEOUT_CYC: abort to IDLE, set err=1 (sticky until reset), pulse done.
  - instruction, rdata and pc are left unchanged.
- MEM_TIMEOUT_EN undefined:
  - Waits indefinitely; err tied to 0; no counter logic.

Decomposition:
- Package smr_mem_pkg holds:
  - mem_cmd encodings: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10.
  - State enum typedef mau_state_t.
- One sub-module, pc_unit: PC register with RESET_PC, increment and branch-load mux, parametrised by ADDR_W.

Test Plan:
- Reset then req_fetch, mem_ready=1 always, mem[0]=16'hD105 -> mem_cmd=MREAD, mem_addr=0 at cycle 1; done at cycle 2; instruction=16'hD105, pc=1.
- req_load with DA=9'h0A3, mem_ready held low 3 cycles, mem[0x0A3]=16'h1234 -> MREAD for 4 cycles; rdata=16'h1234 one cycle after ready; single done pulse.
- load_addr addr_in=9'h010 then req_store wdata_in=16'hBEEF -> MWRITE, mem_addr=0x010, write_data=16'hBEEF for the whole access; load_addr=9'h020 mid-access does not change mem_addr.
- pc_load pc_target=9'h1FF with req_fetch in the same cycle -> fetch from 0x1FF; pc wraps to 0x000 afterwards.
- Simultaneous req_fetch and req_store, then req_load while busy -> only the fetch executes; the other requests are dropped; exactly one done pulse.
- With MEM_TIMEOUT_EN and TIMEOUT_CYC=15, mem_ready never asserted -> abort after 15 wait cycles, err=1, done pulse, pc unchanged. Async reset asserted mid-FETCH -> mem_cmd=MNONE immediately, pc=RESET_PC, err=0.
